// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encoding and NOP payload for pipeline stages
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_e;

  // ADDI x0,x0,0: the payload a bubble carries downstream.
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/pipe_stage_if.sv
// rtl/pipe_stage_if.sv - upstream/downstream valid-ready handshake bundle
interface pipe_stage_if #(
  parameter int DATA_W = 32
);

  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;

  // master: the surroundings (producer upstream, consumer downstream)
  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data
  );

  // slave: the stage itself
  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data
  );

endinterface

// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - one payload register with load and clear (clear wins)
module pipe_skid_reg #(
  parameter int                DATA_W  = 32,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (clear) begin
      data_d = RST_VAL;
    end else if (load) begin
      data_d = d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= RST_VAL;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/pipe_stage.sv
// rtl/pipe_stage.sv - registered valid/ready pipeline stage; PIPE_STAGE_SKID_EN selects the 2-entry skid build
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] NOP_DATA = DATA_W'(NOP_INSN)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  pipe_stage_if.slave  bus,
  output logic [1:0]   occ
);

  pipe_state_e       state_q;
  pipe_state_e       state_d;
  logic              m_valid_q;
  logic              m_valid_d;
  logic              main_load;
  logic              main_clr;
  logic [DATA_W-1:0] main_in;
  logic [DATA_W-1:0] main_q;
  logic              s_fire;
  logic              m_fire;

  assign m_fire = m_valid_q & bus.m_ready;

  pipe_skid_reg #(
    .DATA_W  (DATA_W),
    .RST_VAL (NOP_DATA)
  ) u_main (
    .clk   (clk),
    .rst_n (rst),
    .load  (main_load),
    .clear (main_clr),
    .d     (main_in),
    .q     (main_q)
  );

`ifdef PIPE_STAGE_SKID_EN

  logic              s_ready_q;
  logic              s_ready_d;
  logic              skid_load;
  logic              skid_clr;
  logic              main_from_skid;
  logic [DATA_W-1:0] skid_q;

  assign s_fire  = bus.s_valid & s_ready_q;
  assign main_in = main_from_skid ? skid_q : bus.s_data;

  pipe_skid_reg #(
    .DATA_W  (DATA_W),
    .RST_VAL (NOP_DATA)
  ) u_skid (
    .clk   (clk),
    .rst_n (rst),
    .load  (skid_load),
    .clear (skid_clr),
    .d     (bus.s_data),
    .q     (skid_q)
  );

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_clr       = 1'b0;
    skid_load      = 1'b0;
    skid_clr       = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_d  = EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (s_fire) begin
            state_d   = ONE;
            main_load = 1'b1;
          end
        end
        ONE: begin
          if (s_fire && m_fire) begin
            main_load = 1'b1;
          end else if (m_fire) begin
            state_d  = EMPTY;
            main_clr = 1'b1;
          end else if (s_fire) begin
            state_d   = FULL;
            skid_load = 1'b1;
          end
        end
        FULL: begin
          // s_ready is low here, so only the head can leave; skid slides into main.
          if (m_fire) begin
            state_d        = ONE;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
          end
        end
        default: begin
          state_d  = EMPTY;
          main_clr = 1'b1;
          skid_clr = 1'b1;
        end
      endcase
    end
    m_valid_d = (state_d != EMPTY);
    s_ready_d = (state_d != FULL);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_ready_q <= 1'b1;
    end else begin
      s_ready_q <= s_ready_d;
    end
  end

  assign bus.s_ready = s_ready_q;
  assign occ         = state_q;

`else

  // Single register: accept whenever the held entry is leaving or there is none.
  assign bus.s_ready = bus.m_ready | ~m_valid_q;
  assign s_fire      = bus.s_valid & bus.s_ready;
  assign main_in     = bus.s_data;

  always_comb begin
    state_d   = state_q;
    main_load = 1'b0;
    main_clr  = 1'b0;
    if (flush) begin
      state_d  = EMPTY;
      main_clr = 1'b1;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (s_fire) begin
            state_d   = ONE;
            main_load = 1'b1;
          end
        end
        ONE: begin
          if (s_fire) begin
            main_load = 1'b1;
          end else if (m_fire) begin
            state_d  = EMPTY;
            main_clr = 1'b1;
          end
        end
        default: begin
          state_d  = EMPTY;
          main_clr = 1'b1;
        end
      endcase
    end
    m_valid_d = (state_d != EMPTY);
  end

  assign occ = {1'b0, m_valid_q};

`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= EMPTY;
      m_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_valid_q <= m_valid_d;
    end
  end

  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = main_q;

endmodule
